// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control unit: FSM sequencing fetch/decode/exec/mem/wb.
// Ports: clk, rst_n, opcode/funct3/funct7, zero, lt, mem_ready in;
//   datapath enables and mux selects, alu_control, retired, state_dbg out.
// Build option: define ILLEGAL_TRAP_EN to trap unknown opcodes in TRAP.
module multicycle_controller #(
  parameter int CNT_W    = 32,
  parameter int ALUCTL_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic                zero,
  input  logic                lt,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                adr_src,
  output logic                mem_req,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic [1:0]          result_src,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [2:0]          imm_src,
  output logic [ALUCTL_W-1:0] alu_control,
  output logic [CNT_W-1:0]    retired,
  output logic [3:0]          state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALWB    = 4'd12,
`ifdef ILLEGAL_TRAP_EN
    S_LUI      = 4'd13,
    S_TRAP     = 4'd14
`else
    S_LUI      = 4'd13
`endif
  } state_t;

  state_t     state, nxt;
  logic       taken;
  logic [2:0] alu_op;
  logic       unused;

  assign unused    = ^{funct7[6], funct7[4:0]};
  assign state_dbg = state;

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    nxt = state;
    case (state)
      S_FETCH:    nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          7'b0000011,
          7'b0100011: nxt = S_MEMADR;
          7'b0110011: nxt = S_EXECR;
          7'b0010011: nxt = S_EXECI;
          7'b1100011: nxt = S_BRANCH;
          7'b1101111: nxt = S_JAL;
          7'b1100111: nxt = S_JALR;
          7'b0110111: nxt = S_LUI;
`ifdef ILLEGAL_TRAP_EN
          default:    nxt = S_TRAP;
`else
          default:    nxt = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   nxt = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  nxt = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    nxt = S_FETCH;
      S_MEMWRITE: nxt = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    nxt = S_ALUWB;
      S_EXECI:    nxt = S_ALUWB;
      S_ALUWB:    nxt = S_FETCH;
      S_BRANCH:   nxt = S_FETCH;
      S_JAL:      nxt = S_JALWB;
      S_JALR:     nxt = S_JALWB;
      S_JALWB:    nxt = S_FETCH;
      S_LUI:      nxt = S_ALUWB;
      default:    nxt = state;
    endcase
  end

  // An instruction retires on the cycle that leaves for FETCH;
  // FETCH stalling in place is not a retirement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      retired <= '0;
    end else begin
      state <= nxt;
      if (nxt == S_FETCH && state != S_FETCH)
        retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    alu_op = 3'b000;
    case (funct3)
      3'b000:  alu_op = (state == S_EXECR && funct7[5]) ? 3'b001 : 3'b000;
      3'b010:  alu_op = 3'b101;
      3'b100:  alu_op = 3'b100;
      3'b110:  alu_op = 3'b011;
      3'b111:  alu_op = 3'b010;
      default: alu_op = 3'b000;
    endcase
  end

  always_comb begin
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    imm_src     = 3'b000;
    alu_control = '0;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = 3'b010;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = opcode[5] ? 3'b001 : 3'b000;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      S_EXECR: begin
        alu_src_a        = 2'b10;
        alu_control[2:0] = alu_op;
      end
      S_EXECI: begin
        alu_src_a        = 2'b10;
        alu_src_b        = 2'b01;
        alu_control[2:0] = alu_op;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a        = 2'b10;
        alu_control[2:0] = 3'b001;
        pc_write         = taken;
      end
      S_JAL: pc_write = 1'b1;
      S_JALR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = 1'b1;
      end
      S_JALWB: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        reg_write  = 1'b1;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        imm_src   = 3'b011;
      end
      default: ;
    endcase
    // Reset holds every side-effecting enable low, FETCH included.
    if (!rst_n) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      mem_req   = 1'b0;
    end
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle RV32I control unit, next generation of the single-cycle Controller/MainController/ALUController split.
- An FSM sequences the shared datapath: fetch, decode, execute, memory and writeback.
- Adds a memory ready handshake and funct3-resolved branches (beq/bne/blt/bge).
- Adds a retired-instruction counter.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- ALUCTL_W, 3, width of alu_control. Must be >=3; bits above [2:0] are driven 0.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- opcode  in  7  instr[6:0] from the instruction register
- funct3  in  3  instr[14:12]
- funct7  in  7  instr[31:25]; only bit 5 is used
- zero  in  1  ALU result == 0
- lt  in  1  signed rs1 < rs2 from the ALU compare
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  PC register load
- adr_src  out  1  memory address: 0=PC, 1=ALUOut
- mem_req  out  1  memory access request
- mem_write  out  1  memory write enable
- ir_write  out  1  load the IR and OldPC registers
- reg_write  out  1  register file write
- result_src  out  2  result mux: 00=ALUOut, 01=Data, 10=ALUResult
- alu_src_a  out  2  ALU A mux: 00=PC, 01=OldPC, 10=rs1, 11=zero
- alu_src_b  out  2  ALU B mux: 00=rs2, 01=imm, 10=4
- imm_src  out  3  immediate type: 000=I, 001=S, 010=B, 011=U, 100=J
- alu_control  out  ALUCTL_W  ALU op: 000=add, 001=sub, 010=and, 011=or, 100=xor, 101=slt
- retired  out  CNT_W  count of retired instructions
- state_dbg  out  4  current state encoding

Behaviour:
Reset and output timing
- Reset is asynchronous and active-low: the FSM goes to FETCH and retired clears to 0.
- While rst_n=0, pc_write, ir_write, reg_write, mem_write and mem_req are forced to 0.
- Outputs are decoded combinationally from the state; pc_write and ir_write also depend on mem_ready, zero and lt.
- Any output not listed for a state is 0, and alu_control defaults to add.

State encodings (state_dbg)
- FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, JALR=11, JALWB=12, LUI=13, TRAP=14.

States and transitions
- FETCH: mem_req=1, adr_src=0, A=PC, B=4, add, result_src=10. Stalls while mem_ready=0 with no writes. On mem_ready: ir_write=1, pc_write=1, go to DECODE.
- DECODE: A=OldPC, B=imm, imm_src=B, add. Next state by opcode:
  - 0000011 and 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - any other opcode: see Optional Feature.
- MEMADR: A=rs1, B=imm, add; imm_src=I for loads, S for stores. Goes to MEMREAD (load) or MEMWRITE (store).
- MEMREAD: mem_req=1, adr_src=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1, all held until mem_ready, then FETCH.
- EXECR: A=rs1, B=rs2, then ALUWB.
- EXECI: A=rs1, B=imm, imm_src=I, then ALUWB.
- ALUWB: result_src=00, reg_write=1, then FETCH.
- BRANCH: A=rs1, B=rs2, sub, result_src=00, then FETCH.
  - pc_write = taken; taken is: funct3 000 -> zero; 001 -> !zero; 100 -> lt; 101 -> !lt.
  - Any other funct3 is not taken.
- JAL: result_src=00 (target computed in DECODE), pc_write=1, then JALWB.
- JALR: A=rs1, B=imm, imm_src=I, add, result_src=10, pc_write=1, then JALWB.
- JALWB: A=OldPC, B=4, add, result_src=10, reg_write=1, then FETCH.
- LUI: A=zero, B=imm, imm_src=U, add, then ALUWB.

ALU decode (EXECR and EXECI), by funct3
- 000 -> sub if EXECR and funct7[5]=1, otherwise add.
- 010 -> slt; 100 -> xor; 110 -> or; 111 -> and.
- Any other funct3 -> add.

Retired counter
- Increments by 1 on the final cycle of each instruction: the cycle that transitions to FETCH.
- MEMWRITE counts only on its mem_ready cycle.
- Wraps from all-ones to 0.

Mid-operation events
- rst_n deasserting mid-instruction abandons the instruction; it is not counted.
- mem_ready during a non-memory state is ignored.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE goes to TRAP. TRAP holds all enables at 0, never exits except by reset, and presents state_dbg=14.
- Undefined: an unknown opcode is a NOP. DECODE goes directly to FETCH and retired increments. The TRAP state does not exist.

Test Plan:
- Reset low mid-MEMREAD, then release -> state_dbg=0, retired=0, all enables 0 while low; the first FETCH asserts mem_req=1.
- FETCH with mem_ready low for 3 cycles then high -> pc_write/ir_write=0 for 3 cycles, then =1 for exactly one cycle; state_dbg goes 0 -> 1.
- add (0110011, funct3 000, funct7 0x00) vs sub (funct7 0x20) -> EXECR alu_control=000 vs 001; ALUWB reg_write=1; retired +1 each.
- bne (funct3 001): zero=1 -> pc_write=0 in BRANCH; zero=0 -> pc_write=1. blt (100) with lt=1 -> pc_write=1; funct3 010 -> pc_write=0.
- sw with mem_ready delayed 2 cycles -> mem_write=1 held for 3 MEMWRITE cycles, then FETCH; lw path visits 2,3,4 with reg_write=1 only in MEMWB.
- opcode 0000000 -> with ILLEGAL_TRAP_EN, state_dbg=14 and stuck; without it, next state FETCH and retired +1.
